// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the register-file write-port scheduler.
package regfile_pkg;
  localparam int NREG = 8;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int CW = 3;
  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] reg_data_t;
  typedef struct packed {
    logic      valid;
    reg_idx_t  idx;
    reg_data_t data;
  } wb_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bits, long-op counter and decode stall.
// REGFILE_SCHED_BYPASS_EN: a source being staged this cycle does not stall.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int LONG_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  reg_idx_t        iss_rs,
  input  reg_idx_t        iss_rt,
  input  logic            iss_rs_used,
  input  logic            iss_rt_used,
  input  logic            iss_wr_en,
  input  reg_idx_t        iss_rd,
  input  logic            iss_long,
  input  logic            clr_en,
  input  reg_idx_t        clr_idx,
  input  logic            b_acc,
  output logic            iss_stall,
  output logic [NREG-1:0] pending,
  output logic [CW-1:0]   long_cnt
);
  logic rs_busy, rt_busy, accept, inc;
  logic [NREG-1:0] set_mask, clr_mask;
`ifdef REGFILE_SCHED_BYPASS_EN
  assign rs_busy = pending[iss_rs] && !(clr_en && clr_idx == iss_rs);
  assign rt_busy = pending[iss_rt] && !(clr_en && clr_idx == iss_rt);
`else
  assign rs_busy = pending[iss_rs];
  assign rt_busy = pending[iss_rt];
`endif
  assign iss_stall = iss_valid && ((iss_rs_used && rs_busy) || (iss_rt_used && rt_busy) ||
                     (iss_wr_en && pending[iss_rd]) || (iss_long && long_cnt == CW'(LONG_DEPTH)));
  assign accept = iss_valid && !iss_stall;
  assign inc = accept && iss_long;
  assign set_mask = (accept && iss_wr_en && iss_rd != '0) ? NREG'(1) << iss_rd : '0;
  assign clr_mask = clr_en ? NREG'(1) << clr_idx : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      long_cnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (inc && !b_acc) long_cnt <= long_cnt + CW'(1);
      else if (b_acc && !inc && long_cnt != '0) long_cnt <= long_cnt - CW'(1);
    end
endmodule

// File: rtl/regfile_port_scheduler.sv
// regfile_port_scheduler: hazard scoreboard plus single write-port arbiter (A over B).
// REGFILE_SCHED_BYPASS_EN removes the one-bubble penalty after a commit.
module regfile_port_scheduler import regfile_pkg::*; #(
  parameter int LONG_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      iss_valid,
  input  reg_idx_t  iss_rs,
  input  reg_idx_t  iss_rt,
  input  logic      iss_rs_used,
  input  logic      iss_rt_used,
  input  logic      iss_wr_en,
  input  reg_idx_t  iss_rd,
  input  logic      iss_long,
  output logic      iss_stall,
  input  logic      a_valid,
  input  reg_idx_t  a_reg,
  input  reg_data_t a_data,
  input  logic      b_valid,
  input  reg_idx_t  b_reg,
  input  reg_data_t b_data,
  output logic      b_ready,
  output logic      rf_regwrite,
  output reg_idx_t  rf_writereg,
  output reg_data_t rf_writedata,
  output logic      err_sticky
);
  wb_req_t win;
  logic stage;
  logic [NREG-1:0] pending;
  logic [CW-1:0] long_cnt;
  assign b_ready = b_valid && !a_valid;
  assign win.valid = a_valid || b_valid;
  assign win.idx = a_valid ? a_reg : b_reg;
  assign win.data = a_valid ? a_data : b_data;
  // r0 is never staged, so it never commits and never clears anything
  assign stage = win.valid && win.idx != '0;
  regfile_scoreboard #(.LONG_DEPTH(LONG_DEPTH)) u_sb (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_rs_used(iss_rs_used), .iss_rt_used(iss_rt_used), .iss_wr_en(iss_wr_en),
    .iss_rd(iss_rd), .iss_long(iss_long), .clr_en(stage), .clr_idx(win.idx),
    .b_acc(b_ready), .iss_stall(iss_stall), .pending(pending), .long_cnt(long_cnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_regwrite <= 1'b0;
      rf_writereg <= '0;
      rf_writedata <= '0;
      err_sticky <= 1'b0;
    end else begin
      rf_regwrite <= stage;
      if (stage) begin
        rf_writereg <= win.idx;
        rf_writedata <= win.data;
      end
      if ((stage && !pending[win.idx]) || (b_ready && long_cnt == '0)) err_sticky <= 1'b1;
    end
endmodule

// File: tb/tb_regfile_port_scheduler.sv
// tb_regfile_port_scheduler: directed scenarios plus random traffic against a reference model.
module tb_regfile_port_scheduler;
  localparam int LD = 2;
  logic clk = 0, rst_n = 0;
  logic iss_valid = 0, iss_rs_used = 0, iss_rt_used = 0, iss_wr_en = 0, iss_long = 0;
  logic [2:0] iss_rs = 0, iss_rt = 0, iss_rd = 0, a_reg = 0, b_reg = 0;
  logic a_valid = 0, b_valid = 0;
  logic [15:0] a_data = 0, b_data = 0;
  logic iss_stall, b_ready, rf_regwrite, err_sticky;
  logic [2:0] rf_writereg;
  logic [15:0] rf_writedata;
  int n_chk = 0, n_err = 0;
  logic [7:0] m_pend;
  int m_cnt;
  logic m_we, m_err;
  logic [2:0] m_wreg;
  logic [15:0] m_wdata;

  regfile_port_scheduler #(.LONG_DEPTH(LD)) dut (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_rs_used(iss_rs_used), .iss_rt_used(iss_rt_used), .iss_wr_en(iss_wr_en),
    .iss_rd(iss_rd), .iss_long(iss_long), .iss_stall(iss_stall), .a_valid(a_valid),
    .a_reg(a_reg), .a_data(a_data), .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data),
    .b_ready(b_ready), .rf_regwrite(rf_regwrite), .rf_writereg(rf_writereg),
    .rf_writedata(rf_writedata), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // A source is busy while its write is outstanding, unless (bypass build) it is being staged now
  function automatic logic src_busy(input logic [2:0] r);
    logic [2:0] w;
    w = a_valid ? a_reg : b_reg;
`ifdef REGFILE_SCHED_BYPASS_EN
    if ((a_valid || b_valid) && w == r && r != 0) return 1'b0;
`endif
    return m_pend[r];
  endfunction

  function automatic logic exp_stall();
    return iss_valid && ((iss_rs_used && src_busy(iss_rs)) || (iss_rt_used && src_busy(iss_rt)) ||
           (iss_wr_en && m_pend[iss_rd]) || (iss_long && m_cnt == LD));
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_pend <= 0; m_cnt <= 0; m_we <= 0; m_wreg <= 0; m_wdata <= 0; m_err <= 0;
    end else begin : upd
      logic [7:0] p;
      int c;
      logic acc, bacc;
      logic [2:0] w;
      p = m_pend;
      c = m_cnt;
      acc = iss_valid && !exp_stall();
      bacc = b_valid && !a_valid;
      w = a_valid ? a_reg : b_reg;
      m_we <= 0;
      if ((a_valid || b_valid) && w != 0) begin
        m_we <= 1; m_wreg <= w; m_wdata <= a_valid ? a_data : b_data;
        if (!p[w]) m_err <= 1;
        p[w] = 0;
      end
      if (bacc && c == 0) m_err <= 1;
      if (acc && iss_wr_en && iss_rd != 0) p[iss_rd] = 1;
      if (acc && iss_long && !bacc) c++;
      else if (bacc && !(acc && iss_long) && c > 0) c--;
      m_pend <= p;
      m_cnt <= c;
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("m_stall", iss_stall, exp_stall());
      chk("m_b_ready", b_ready, b_valid && !a_valid);
      chk("m_regwrite", rf_regwrite, m_we);
      chk("m_writereg", rf_writereg, m_wreg);
      chk("m_writedata", rf_writedata, m_wdata);
      chk("m_err", err_sticky, m_err);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs_used = 0; iss_rt_used = 0; iss_wr_en = 0; iss_long = 0;
    iss_rs = 0; iss_rt = 0; iss_rd = 0; a_valid = 0; b_valid = 0;
  endtask

  task automatic issue(input logic [2:0] rd, input logic lng);
    idle();
    iss_valid = 1; iss_wr_en = 1; iss_rd = rd; iss_long = lng;
  endtask

  function automatic logic [2:0] pick();
    logic [2:0] s, k;
    s = 3'($urandom);
    for (int i = 0; i < 8; i++) begin
      k = s + 3'(i);
      if (m_pend[k]) return k;
    end
    return s;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_we", rf_regwrite, 0); chk("rst_wreg", rf_writereg, 0);
    chk("rst_wdata", rf_writedata, 0); chk("rst_err", err_sticky, 0);
    issue(3, 0); tick();
    idle(); a_valid = 1; a_reg = 5; a_data = 16'hFFFF; tick();
    chk("pre_rst_we", rf_regwrite, 1); chk("pre_rst_err", err_sticky, 1);
    idle(); rst_n = 0; #1;
    chk("mid_rst_we", rf_regwrite, 0); chk("mid_rst_wreg", rf_writereg, 0);
    chk("mid_rst_wdata", rf_writedata, 0); chk("mid_rst_err", err_sticky, 0);
    tick(); rst_n = 1;
    issue(0, 0); iss_rs_used = 1; iss_rs = 3; #1;
    chk("rst_clears_pending", iss_stall, 0);
    tick();
    issue(0, 0); iss_rs_used = 1; iss_rt_used = 1; a_valid = 1; a_reg = 0; a_data = 16'hDEAD; #1;
    chk("r0_no_stall", iss_stall, 0);
    tick(); idle(); #1;
    chk("r0_no_write", rf_regwrite, 0);
    issue(3, 0); tick();
    idle(); iss_valid = 1; iss_rs_used = 1; iss_rs = 3; #1;
    chk("raw_stall", iss_stall, 1);
    tick(); a_valid = 1; a_reg = 3; a_data = 16'h1234; #1;
`ifdef REGFILE_SCHED_BYPASS_EN
    chk("raw_stage_cycle", iss_stall, 0);
`else
    chk("raw_stage_cycle", iss_stall, 1);
`endif
    tick(); a_valid = 0; #1;
    chk("raw_we", rf_regwrite, 1); chk("raw_wreg", rf_writereg, 3);
    chk("raw_wdata", rf_writedata, 16'h1234); chk("raw_release", iss_stall, 0);
    tick();
    issue(2, 0); tick();
    issue(5, 1); tick();
    idle(); a_valid = 1; a_reg = 2; a_data = 16'hAAAA; b_valid = 1; b_reg = 5; b_data = 16'h5555; #1;
    chk("conf_b_blocked", b_ready, 0);
    tick(); a_valid = 0; #1;
    chk("conf_a_wreg", rf_writereg, 2); chk("conf_a_wdata", rf_writedata, 16'hAAAA);
    chk("conf_b_ready", b_ready, 1);
    tick(); b_valid = 0; #1;
    chk("conf_b_wreg", rf_writereg, 5); chk("conf_b_wdata", rf_writedata, 16'h5555);
    chk("conf_err", err_sticky, 0);
    issue(1, 1); tick();
    issue(2, 1); tick();
    issue(4, 1); #1;
    chk("long_full", iss_stall, 1);
    tick(); b_valid = 1; b_reg = 1; b_data = 16'h1111; #1;
    chk("long_b_ready", b_ready, 1); chk("long_still_full", iss_stall, 1);
    tick(); b_reg = 2; b_data = 16'h2222; #1;
    chk("long_release", iss_stall, 0);
    tick(); iss_valid = 0; b_reg = 4; b_data = 16'h4444;
    tick(); idle(); issue(6, 1); #1;
    chk("long_empty0", iss_stall, 0);
    tick(); issue(7, 1); #1;
    chk("long_empty1", iss_stall, 0);
    tick(); idle(); b_valid = 1; b_reg = 6;
    tick(); b_reg = 7;
    tick(); idle();
    issue(6, 0); tick(); #1;
    chk("waw_stall", iss_stall, 1);
    tick(); a_valid = 1; a_reg = 6; a_data = 16'h6666; #1;
    chk("waw_stage", iss_stall, 1);
    tick(); a_valid = 0; #1;
    chk("waw_release", iss_stall, 0);
    tick(); idle(); a_valid = 1; a_reg = 6;
    tick(); idle(); #1;
    chk("err_clean", err_sticky, 0);
    a_valid = 1; a_reg = 7; a_data = 16'h7777;
    tick(); idle(); #1;
    chk("err_we", rf_regwrite, 1); chk("err_wreg", rf_writereg, 7);
    chk("err_wdata", rf_writedata, 16'h7777); chk("err_set", err_sticky, 1);
    repeat (3) tick();
    chk("err_holds", err_sticky, 1);
    rst_n = 0; #1;
    chk("err_rst", err_sticky, 0);
    tick(); rst_n = 1;
    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0; tick(); rst_n = 1;
      end
      iss_valid = 1'($urandom); iss_rs = 3'($urandom); iss_rt = 3'($urandom);
      iss_rs_used = 1'($urandom); iss_rt_used = 1'($urandom); iss_rd = 3'($urandom);
      iss_wr_en = ($urandom_range(0, 3) != 0); iss_long = ($urandom_range(0, 3) == 0);
      a_valid = ($urandom_range(0, 2) == 0); a_data = 16'($urandom);
      a_reg = ($urandom_range(0, 9) < 8) ? pick() : 3'($urandom);
      b_valid = (m_cnt > 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
      b_reg = pick(); b_data = 16'($urandom);
      tick();
    end
    idle(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_port_scheduler.md
Name: regfile_port_scheduler

Overview:
Hazard scoreboard and write-port scheduler for the 8x16-bit register file of the pipelined 16-bit MIPS core.
- Holds a per-register pending-write bit and stalls decode on RAW or WAW hazards.
- Counts outstanding long-latency ops, such as the multi-cycle multiplier.
- Shares the register file's single write port between the fixed-latency pipeline writeback (source A) and the long-latency unit (source B).
- Sits between decode, the writeback stage and the register file write port.

Parameters:
- NREG, 8, number of architectural registers.
- AW, 3, register index width.
- DW, 16, data width.
- LONG_DEPTH, 2, maximum in-flight long-latency ops (1..7).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  decode presents an instruction.
- iss_rs  in  AW  source register 1.
- iss_rt  in  AW  source register 2.
- iss_rs_used  in  1  rs is read.
- iss_rt_used  in  1  rt is read.
- iss_wr_en  in  1  instruction writes rd.
- iss_rd  in  AW  destination register.
- iss_long  in  1  instruction goes to the long-latency unit.
- iss_stall  out  1  decode must hold; combinational.
- a_valid  in  1  pipeline writeback valid; cannot be back-pressured.
- a_reg  in  AW  pipeline writeback register.
- a_data  in  DW  pipeline writeback data.
- b_valid  in  1  long unit result valid.
- b_reg  in  AW  long unit result register.
- b_data  in  DW  long unit result data.
- b_ready  out  1  long unit result accepted this cycle; combinational.
- rf_regwrite  out  1  register file write enable; registered.
- rf_writereg  out  AW  register file write index; registered.
- rf_writedata  out  DW  register file write data; registered.
- err_sticky  out  1  commit to a non-pending register was seen; registered.

Behaviour:
- Reset: pending[NREG-1:0]=0, long_cnt=0, rf_regwrite=0, rf_writereg=0, rf_writedata=0, err_sticky=0.
  - Reset asserted mid-operation discards all pending state and any staged write.
- Stall: iss_stall = iss_valid and any of the following:
  - iss_rs_used and pending[iss_rs].
  - iss_rt_used and pending[iss_rt].
  - iss_wr_en and pending[iss_rd] (WAW).
  - iss_long and long_cnt==LONG_DEPTH.
- Stall uses only the registered pending bits. A register committed this cycle still stalls its reader this cycle; the reader is released the next cycle. That is one bubble after commit, without the optional feature.
- Issue accept: iss_valid and not iss_stall.
  - If iss_wr_en and iss_rd!=0, set pending[iss_rd].
  - If iss_long, long_cnt+1.
- Register 0: never marked pending, never stalls, never written. rf_regwrite stays 0 for index 0, so r0 stays 0 even though the register file also forces it.
- Arbitration: source A has absolute priority.
  - b_ready = b_valid and not a_valid.
  - The winner is staged into the rf_* registers at the next posedge (latency 1). The register file commits it at the following negedge.
  - No winner: rf_regwrite=0; rf_writereg and rf_writedata hold their values.
- Commit: pending[x] clears on the same posedge that stages a write to x.
  - A B acceptance also decrements long_cnt. A B acceptance with long_cnt==0 sets err_sticky.
  - A staged write to a register whose pending bit is 0 sets err_sticky. The write is still performed.
- Simultaneous set and clear of the same register cannot occur, because WAW stalls it. If it does occur, the set wins.
- Simultaneous long issue and B acceptance: long_cnt is unchanged.
- long_cnt saturates. There is no increment at LONG_DEPTH because stall prevents it, and no decrement below 0.

Optional Feature:
- Macro REGFILE_SCHED_BYPASS_EN.
- When defined: a source register equal to the register being staged this cycle (A winner, or B when b_ready) does not stall.
  - This is legal because the register file write lands at the negedge before decode's next read.
  - Removes the one-bubble penalty.
- When undefined: the strict registered-pending behaviour above.

Decomposition:
- regfile_pkg holds:
  - constants NREG=8, AW=3, DW=16;
  - typedef reg_idx_t (AW bits);
  - typedef reg_data_t (DW bits);
  - typedef wb_req_t (valid, idx, data).
- One sub-module, regfile_scoreboard: pending bit vector, long_cnt, stall logic.
- The top keeps the arbiter, the staging registers and err_sticky.

Test Plan:
- Reset/r0:
  - Assert rst_n=0 mid-stream, then issue wr_en rd=0.
  - Required: all outputs 0, pending stays 0, no stall, rf_regwrite never 1 for index 0.
- RAW stall:
  - Issue rd=3; next cycle issue rs=3.
  - Required: stall until a_valid a_reg=3 a_data=16'h1234 is staged; rf_regwrite=1, rf_writereg=3, rf_writedata=16'h1234 one cycle later; stall drops the following cycle.
  - With REGFILE_SCHED_BYPASS_EN, stall drops in the staging cycle.
- Port conflict:
  - a_valid (reg 2, 16'hAAAA) and b_valid (reg 5, 16'h5555) in the same cycle.
  - Required: b_ready=0; reg 2 staged first; b_ready=1 next cycle; reg 5 staged one cycle after that.
- Long depth:
  - Issue 3 long ops to r1, r2, r4 with LONG_DEPTH=2.
  - Required: third stalls until the first B result is accepted; long_cnt returns to 0 after all results.
- WAW:
  - Issue rd=6 twice back-to-back.
  - Required: second stalls until reg 6 commits.
- Error:
  - a_valid with a_reg=7 while pending[7]=0.
  - Required: write performed; err_sticky=1 and stays 1 until reset.
